fifo_word_packer: RTL and testbench
===================================

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter width, default 8: bit width of one FIFO entry.
REQ-002 Parameter lanes, default 4: FIFO entries packed into one output word.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 empty  input  1  upstream sync_fifo empty flag.
REQ-006 data_out  input  width  upstream sync_fifo read data, valid the cycle after r_en.
REQ-007 r_en  output  1  read enable to upstream sync_fifo.
REQ-008 flush  input  1  single-cycle pulse; emit a partially filled word.
REQ-009 out_data  output  width*lanes  packed word; lane 0 (first entry read) in bits [width-1:0].
REQ-010 out_valid  output  1  out_data/out_count valid.
REQ-011 out_ready  input  1  downstream accepts word when out_valid&&out_ready.
REQ-012 out_count  output  $clog2(lanes+1)  number of valid lanes in out_data (1..lanes).

Function
REQ-013 States FILL and SEND only; FILL after reset.
REQ-014 Registers: cnt (lanes captured), inflight (r_en issued last cycle), flush_pend.
REQ-015 r_en combinational = state==FILL && !empty && !flush_pend && (cnt+inflight) < lanes.
REQ-016 r_en never asserts while empty==1 or in SEND.
REQ-017 Read latency 1: when inflight==1, data_out is written to lane cnt and cnt increments that cycle.
REQ-018 Streaming: with empty==0 throughout, r_en asserts every cycle until lanes reads are issued.
REQ-019 FILL->SEND on the cycle cnt reaches lanes (capture of last lane); out_valid high the next cycle.
REQ-020 In SEND, out_data, out_count and out_valid hold stable until out_ready==1.
REQ-021 On handshake: out_valid->0, cnt->0, out_data lanes cleared to 0, flush_pend->0, state->FILL; r_en may assert the following cycle.
REQ-022 flush in FILL with cnt>0 or inflight==1: set flush_pend, stop reads, capture any inflight entry, then go SEND with out_count=cnt.
REQ-023 flush in FILL with cnt==0 and inflight==0: ignored, no output word.
REQ-024 flush during SEND: ignored.
REQ-025 Unfilled lanes of a partial word read as 0.
REQ-026 flush coincident with the capture completing cnt==lanes: word sent as full (out_count=lanes); flush has no further effect.
REQ-027 empty rising while reads inflight: inflight entry still captured; packer waits in FILL, no timeout.

Reset
REQ-028 On clk edge with rst==0: state=FILL, cnt=0, inflight=0, flush_pend=0, out_data=0, out_valid=0, out_count=0; r_en=0 the same cycle.
REQ-029 Reset mid-operation discards partial lanes and any inflight entry; the upstream FIFO is reset from the same rst.

Structure
REQ-030 Package fifo_pack_pkg holds the state enum typedef (FILL, SEND) and default width/lanes constants.
REQ-031 Single module, no sub-modules; lane storage is one width*lanes register indexed by cnt.

Verification (width=8, lanes=4, paired with sync_fifo depth 8)
REQ-032 Write 0x11,0x22,0x33,0x44 into FIFO, out_ready=1 -> one word 0x44332211, out_count=4, r_en four consecutive cycles.
REQ-033 Write 8 bytes 0x01..0x08, out_ready=0 for 10 cycles then 1 -> 0x04030201 held stable, then 0x08070605; r_en low throughout SEND.
REQ-034 Write 0xA1,0xB2 then flush after capture -> out_data 0x0000B2A1, out_count=2.
REQ-035 flush with FIFO empty and cnt=0 -> out_valid stays 0 for 20 cycles.
REQ-036 Write 3 bytes, rst=0 for one cycle after second capture -> all outputs 0; no word emitted for discarded bytes.
REQ-037 Assertion throughout all tests: never r_en==1 while empty==1.

Source files
------------

// File: rtl/fifo_pack_pkg.sv
// Shared types and defaults for the FIFO word packer.
// No logic: state encoding and default lane geometry only.
// Imported by fifo_word_packer.
package fifo_pack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 4;

  // FILL gathers entries from the upstream FIFO, SEND presents the packed word.
  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } pack_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Packs `lanes` consecutive sync_fifo entries into one wide word, lane 0 = oldest entry.
// Latency: 1-cycle FIFO read latency per entry; word valid the cycle after the last capture.
// Backpressure: word held stable until out_ready; no FIFO reads are issued while a word waits.
module fifo_word_packer
  import fifo_pack_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int lanes = DEF_LANES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       empty,
  input  logic [width-1:0]           data_out,
  output logic                       r_en,
  input  logic                       flush,
  output logic [width*lanes-1:0]     out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(lanes+1)-1:0] out_count
);

  localparam int            CW      = $clog2(lanes + 1);
  localparam logic [CW-1:0] LANES_C = CW'(lanes);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  pack_state_t            r_state;
  pack_state_t            w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [CW-1:0]          w_cnt_sum;
  logic                   r_inflight;
  logic                   r_flush_pend;
  logic                   w_flush_pend_nxt;
  logic                   w_flush_take;
  logic [width*lanes-1:0] r_data;
  logic [width*lanes-1:0] w_data_nxt;
  logic                   r_valid;
  logic                   w_valid_nxt;
  logic [CW-1:0]          r_count;
  logic [CW-1:0]          w_count_nxt;
  logic                   w_r_en;

  // Lanes already captured plus the one whose read data arrives next cycle.
  assign w_cnt_sum = r_cnt + CW'(r_inflight);

  // Reads only while filling, with room left and no flush draining; held off during reset.
  assign w_r_en = rst && (r_state == FILL) && !empty && !r_flush_pend &&
                  (w_cnt_sum < LANES_C);

  // A flush only matters when there is, or soon will be, something to send.
  assign w_flush_take = flush && (r_state == FILL) && ((r_cnt != '0) || r_inflight);

  assign r_en      = w_r_en;
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_count = r_count;

  // Next-state, lane capture and output-word bookkeeping.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_flush_pend_nxt = r_flush_pend;
    w_data_nxt       = r_data;
    w_valid_nxt      = r_valid;
    w_count_nxt      = r_count;

    case (r_state)
      FILL: begin
        // Read data from last cycle's r_en lands in the next free lane.
        if (r_inflight) begin
          w_cnt_nxt = r_cnt + ONE_C;
          for (int i = 0; i < lanes; i++) begin
            if (r_cnt == CW'(i)) begin
              w_data_nxt[i*width +: width] = data_out;
            end
          end
        end
        if (w_flush_take) begin
          w_flush_pend_nxt = 1'b1;
        end
        // Full word, or a flush with nothing left in flight (a read issued in the
        // flush cycle itself is still collected before sending).
        if ((w_cnt_nxt == LANES_C) ||
            ((r_flush_pend || w_flush_take) && !w_r_en)) begin
          w_state_nxt      = SEND;
          w_valid_nxt      = 1'b1;
          w_count_nxt      = w_cnt_nxt;
          w_flush_pend_nxt = 1'b0;
        end
      end
      SEND: begin
        // Handshake: clear the lanes so a later partial word reads zero above out_count.
        if (out_ready) begin
          w_state_nxt      = FILL;
          w_cnt_nxt        = '0;
          w_flush_pend_nxt = 1'b0;
          w_data_nxt       = '0;
          w_valid_nxt      = 1'b0;
          w_count_nxt      = '0;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FILL;
      r_cnt        <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_inflight   <= w_r_en;
      r_flush_pend <= w_flush_pend_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_count      <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer paired with a behavioural depth-8 sync_fifo.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Expected words are built from the written byte stream grouped in fours.
module tb_fifo_word_packer;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int CW = $clog2(L + 1);

  logic           clk;
  logic           rst;
  logic           empty;
  logic [W-1:0]   data_out;
  logic           r_en;
  logic           flush;
  logic [W*L-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_count;

  logic           wr_req;
  logic [7:0]     wr_data;
  logic [7:0]     fifo_q[$];
  logic [31:0]    obs_word[$];
  logic [CW-1:0]  obs_cnt[$];
  int             ren_cyc[$];
  int             cyc    = 0;
  int             checks = 0;
  int             errors = 0;

  fifo_word_packer #(.width(W), .lanes(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .empty     (empty),
    .data_out  (data_out),
    .r_en      (r_en),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream sync_fifo: read data registered one cycle after r_en, shares rst.
  always @(posedge clk) begin
    if (!rst) begin
      fifo_q.delete();
      data_out <= '0;
      empty    <= 1'b1;
    end else begin
      if (r_en && fifo_q.size() > 0) data_out <= fifo_q.pop_front();
      if (wr_req && fifo_q.size() < 8) fifo_q.push_back(wr_data);
      empty <= (fifo_q.size() == 0);
    end
  end

  // Record accepted words and read strobes; r_en must never fire on an empty FIFO.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (out_valid && out_ready) begin
        obs_word.push_back(out_data);
        obs_cnt.push_back(out_count);
      end
      if (r_en) ren_cyc.push_back(cyc);
    end
    checks++;
    if (r_en === 1'b1 && empty === 1'b1) begin
      errors++;
      $display("FAIL ren_while_empty cycle %0d: r_en=%b empty=%b, required r_en=0", cyc, r_en, empty);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    while (fifo_q.size() >= 8 && guard < 200) begin
      tick();
      guard++;
    end
    wr_req  = 1'b1;
    wr_data = b;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (obs_word.size() < n && c < budget) begin
      tick();
      c++;
    end
    checks++;
    if (obs_word.size() < n) begin
      errors++;
      $display("FAIL %s timeout: words=%0d required=%0d", tag, obs_word.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; out_ready = 1'b0; wr_req = 1'b0; wr_data = '0;
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL reset_ren got %b exp 0", r_en); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_full_word();
    int base, r0, n, span;
    logic [31:0] got;
    logic [CW-1:0] gcnt;
    base = obs_word.size();
    r0   = ren_cyc.size();
    out_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_words(base + 1, 50, "full_word");
    repeat (3) tick();
    got  = (obs_word.size() > base) ? obs_word[base] : 'x;
    gcnt = (obs_cnt.size() > base) ? obs_cnt[base] : 'x;
    checks++; if (got !== 32'h44332211) begin errors++; $display("FAIL full_word data got %h exp 44332211", got); end
    checks++; if (gcnt !== 3'd4) begin errors++; $display("FAIL full_word count got %0d exp 4", gcnt); end
    n = ren_cyc.size() - r0;
    checks++; if (n !== 4) begin errors++; $display("FAIL full_word ren_count got %0d exp 4", n); end
    span = (n >= 4) ? ren_cyc[r0+3] - ren_cyc[r0] : -1;
    checks++; if (span !== 3) begin errors++; $display("FAIL full_word ren_consecutive span got %0d exp 3", span); end
  endtask

  task automatic test_backpressure();
    int base, c;
    logic [31:0] g0, g1;
    logic [CW-1:0] c0, c1;
    base = obs_word.size();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    c = 0;
    while (!out_valid && c < 50) begin tick(); c++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b exp 1", out_valid); end
    for (int k = 0; k < 10; k++) begin
      flush = (k == 3);
      @(negedge clk);
      checks++; if (out_data !== 32'h04030201) begin errors++; $display("FAIL hold_data cyc %0d got %h exp 04030201", k, out_data); end
      checks++; if (out_count !== 3'd4) begin errors++; $display("FAIL hold_count cyc %0d got %0d exp 4", k, out_count); end
      checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL hold_ren cyc %0d got %b exp 0", k, r_en); end
      tick();
    end
    flush = 1'b0;
    checks++; if (obs_word.size() !== base) begin errors++; $display("FAIL hold_early words got %0d exp %0d", obs_word.size(), base); end
    out_ready = 1'b1;
    wait_words(base + 2, 60, "backpressure");
    g0 = (obs_word.size() > base)     ? obs_word[base]     : 'x;
    g1 = (obs_word.size() > base + 1) ? obs_word[base + 1] : 'x;
    c0 = (obs_cnt.size() > base)      ? obs_cnt[base]      : 'x;
    c1 = (obs_cnt.size() > base + 1)  ? obs_cnt[base + 1]  : 'x;
    checks++; if (g0 !== 32'h04030201) begin errors++; $display("FAIL bp_word0 got %h exp 04030201", g0); end
    checks++; if (g1 !== 32'h08070605) begin errors++; $display("FAIL bp_word1 got %h exp 08070605", g1); end
    checks++; if (c0 !== 3'd4 || c1 !== 3'd4) begin errors++; $display("FAIL bp_counts got %0d,%0d exp 4,4", c0, c1); end
  endtask

  task automatic test_flush_partial();
    int base;
    logic [31:0] got;
    logic [CW-1:0] gcnt;
    base = obs_word.size();
    out_ready = 1'b1;
    push_byte(8'hA1); push_byte(8'hB2);
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_words(base + 1, 20, "flush_partial");
    got  = (obs_word.size() > base) ? obs_word[base] : 'x;
    gcnt = (obs_cnt.size() > base) ? obs_cnt[base] : 'x;
    checks++; if (got !== 32'h0000B2A1) begin errors++; $display("FAIL flush_data got %h exp 0000b2a1", got); end
    checks++; if (gcnt !== 3'd2) begin errors++; $display("FAIL flush_count got %0d exp 2", gcnt); end
  endtask

  task automatic test_flush_idle();
    int base;
    base = obs_word.size();
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_flush_valid cyc %0d got %b exp 0", k, out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL idle_data_cleared cyc %0d got %h exp 0", k, out_data); end
      tick();
    end
    checks++; if (obs_word.size() !== base) begin errors++; $display("FAIL idle_flush_words got %0d exp %0d", obs_word.size(), base); end
  endtask

  task automatic test_reset_midway();
    int base, r0, c;
    logic [31:0] got;
    logic [CW-1:0] gcnt;
    base = obs_word.size();
    r0   = ren_cyc.size();
    out_ready = 1'b1;
    push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    c = 0;
    while (ren_cyc.size() - r0 < 2 && c < 20) begin tick(); c++; end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL midrst_ren got %b exp 0", r_en); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL midrst_data got %h exp 0", out_data); end
    checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", out_count); end
    rst = 1'b1;
    repeat (20) tick();
    checks++; if (obs_word.size() !== base) begin errors++; $display("FAIL midrst_words got %0d exp %0d", obs_word.size(), base); end
    push_byte(8'hD1); push_byte(8'hD2); push_byte(8'hD3); push_byte(8'hD4);
    wait_words(base + 1, 50, "post_reset");
    got  = (obs_word.size() > base) ? obs_word[base] : 'x;
    gcnt = (obs_cnt.size() > base) ? obs_cnt[base] : 'x;
    checks++; if (got !== 32'hD4D3D2D1) begin errors++; $display("FAIL post_reset_data got %h exp d4d3d2d1", got); end
    checks++; if (gcnt !== 3'd4) begin errors++; $display("FAIL post_reset_count got %0d exp 4", gcnt); end
  endtask

  task automatic test_random_stream();
    int base, c;
    logic [7:0]    exp_b[$];
    logic [31:0]   exp_w, got;
    logic [CW-1:0] gcnt;
    base = obs_word.size();
    for (int i = 0; i < 40; i++) exp_b.push_back(8'($urandom));
    c = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_byte(exp_b[i]);
        end
      end
      begin
        while (obs_word.size() < base + 10 && c < 3000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
          c++;
        end
      end
    join
    out_ready = 1'b1;
    wait_words(base + 10, 100, "random");
    for (int k = 0; k < 10; k++) begin
      exp_w = '0;
      for (int j = 0; j < 4; j++) exp_w = exp_w | (32'(exp_b[4*k + j]) << (8*j));
      got  = (obs_word.size() > base + k) ? obs_word[base + k] : 'x;
      gcnt = (obs_cnt.size() > base + k) ? obs_cnt[base + k] : 'x;
      checks++; if (got !== exp_w) begin errors++; $display("FAIL random_word%0d got %h exp %h", k, got, exp_w); end
      checks++; if (gcnt !== 3'd4) begin errors++; $display("FAIL random_count%0d got %0d exp 4", k, gcnt); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_backpressure();
    test_flush_partial();
    test_flush_idle();
    test_reset_midway();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
